// File: rtl/sim_mem_pkg.sv
// -----------------------------------------------------------------------------
// sim_mem_pkg
//   Shared types, derived widths and helper functions for the memory responder.
//   The *_P localparams are the build-time configuration; the response entry
//   struct is sized from them, so the responder and lane queue parameters must
//   be left at (or set equal to) these values.
// -----------------------------------------------------------------------------
package sim_mem_pkg;

  localparam int unsigned NUM_LANES_P     = 4;
  localparam int unsigned DATA_WIDTH_P    = 64;
  localparam int unsigned LOGSIZE_WIDTH_P = 3;
  localparam int unsigned MEM_WORDS_P     = 256;
  localparam int unsigned LATENCY_P       = 2;
  localparam int unsigned QUEUE_DEPTH_P   = 4;

  // Bytes per word, byte-offset width and word-index width.
  localparam int unsigned NUM_BYTES = DATA_WIDTH_P / 8;
  localparam int unsigned BOFF      = $clog2(NUM_BYTES);
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS_P);

  // Free-running cycle stamp. Two extra bits keep LATENCY well below the wrap
  // distance, so modular subtraction gives a correct age up to LATENCY.
  localparam int unsigned STAMP_W = $clog2(LATENCY_P) + 2;

  typedef logic [STAMP_W-1:0]         stamp_t;
  typedef logic [DATA_WIDTH_P-1:0]    word_t;
  typedef logic [LOGSIZE_WIDTH_P-1:0] size_t;
  typedef logic [BOFF-1:0]            offset_t;

  typedef struct packed {
    logic   is_store;
    size_t  size;
    word_t  data;
    stamp_t stamp;
  } resp_entry_t;

  // Accesses wider than a word are clamped to a full word.
  function automatic size_t eff_size(input size_t size);
    if (size > size_t'(BOFF)) return size_t'(BOFF);
    return size;
  endfunction

  function automatic logic misaligned(input offset_t offset, input size_t esize);
    offset_t mask;
    mask = offset_t'((1 << esize) - 1);
    return (offset & mask) != '0;
  endfunction

  // Wrap-safe age of a stamp relative to the current cycle counter.
  function automatic stamp_t stamp_age(input stamp_t now, input stamp_t stamp);
    return stamp_t'(now - stamp);
  endfunction

  // Overlay the 2^esize low bytes of new_data onto old_word starting at byte
  // position offset. Bytes outside that window keep their old value.
  function automatic word_t merge_bytes(input word_t   old_word,
                                        input word_t   new_data,
                                        input offset_t offset,
                                        input size_t   esize);
    word_t w;
    int    lo;
    int    n;
    w  = old_word;
    lo = int'(offset);
    n  = 1 << esize;
    for (int b = 0; b < int'(NUM_BYTES); b++) begin
      if (b >= lo && b < lo + n) begin
        w[b*8 +: 8] = new_data[(b-lo)*8 +: 8];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sim_mem_lane_queue.sv
// -----------------------------------------------------------------------------
// sim_mem_lane_queue
//   Per-lane timestamped response FIFO. Holds accepted requests until they are
//   at least LATENCY cycles old and the consumer takes them, strictly in order.
//
// Ports
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   a_valid_i        request offered on this lane
//   a_ready_o        a free slot exists (registered count only, no bypass)
//   enq_entry_i      entry captured when a_valid_i && a_ready_o
//   now_i            current cycle counter
//   d_valid_o        head entry present and old enough
//   d_ready_i        consumer accepts the head
//   head_o           head entry fields (zero when empty)
//   busy_next_o      queue will be non-empty after this edge
// -----------------------------------------------------------------------------
module sim_mem_lane_queue
  import sim_mem_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_P,
  parameter int unsigned LATENCY     = LATENCY_P
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  input  resp_entry_t enq_entry_i,
  input  stamp_t      now_i,
  output logic        d_valid_o,
  input  logic        d_ready_i,
  output resp_entry_t head_o,
  output logic        busy_next_o
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned SLOTS = 2 ** PTR_W;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam stamp_t      LAT   = stamp_t'(LATENCY);

  resp_entry_t      entries_q [SLOTS];
  logic [SLOTS-1:0] ripe_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_empty;
  logic             enq;
  logic             deq;

  assign not_empty = (count_q != '0);
  assign a_ready_o = rst_n_i && (count_q < CNT_W'(QUEUE_DEPTH));

  // A head that has waited past the stamp wrap distance stays valid through
  // its ripe bit, so held responses never drop d_valid under backpressure.
  assign d_valid_o = not_empty &&
                     (ripe_q[rd_ptr_q] ||
                      stamp_age(now_i, entries_q[rd_ptr_q].stamp) >= LAT);
  assign head_o    = not_empty ? entries_q[rd_ptr_q] : '0;

  assign enq = a_valid_i && a_ready_o;
  assign deq = d_valid_o && d_ready_i;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign busy_next_o = (count_d != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; it is only observed while
  // count_q says the slot is occupied, and count_q is reset.
  always_ff @(posedge clk_i) begin
    if (enq) entries_q[wr_ptr_q] <= enq_entry_i;
    for (int i = 0; i < int'(SLOTS); i++) begin
      if (enq && wr_ptr_q == PTR_W'(i)) begin
        ripe_q[i] <= 1'b0;
      end else if (stamp_age(now_i, entries_q[i].stamp) >= LAT) begin
        ripe_q[i] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sim_mem_responder.sv
// -----------------------------------------------------------------------------
// sim_mem_responder
//   Multi-lane A/D target: applies per-lane load/store requests to a shared
//   backing memory in the acceptance cycle and returns per-lane, in-order
//   responses no earlier than LATENCY cycles later.
//
// Ports (lane g occupies slice g of every packed vector)
//   clock, reset_n                 clock, asynchronous active-low reset
//   a_valid/a_ready                request handshake
//   a_address/a_is_store/a_size/a_data   request fields
//   d_valid/d_ready                response handshake
//   d_is_store/d_size/d_data       response fields (d_data = 0 for stores)
//   inflight                       some lane holds an undelivered request
//   error                          sticky misaligned-access flag
//
// DATA_WIDTH, LOGSIZE_WIDTH and LATENCY size the shared entry type and must
// equal the sim_mem_pkg configuration.
// -----------------------------------------------------------------------------
module sim_mem_responder
  import sim_mem_pkg::*;
#(
  parameter int unsigned NUM_LANES     = NUM_LANES_P,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_P,
  parameter int unsigned LOGSIZE_WIDTH = LOGSIZE_WIDTH_P,
  parameter int unsigned MEM_WORDS     = MEM_WORDS_P,
  parameter int unsigned LATENCY       = LATENCY_P,
  parameter int unsigned QUEUE_DEPTH   = QUEUE_DEPTH_P
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NUM_LANES-1:0]               a_valid,
  output logic [NUM_LANES-1:0]               a_ready,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_address,
  input  logic [NUM_LANES-1:0]               a_is_store,
  input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] a_size,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_data,
  output logic [NUM_LANES-1:0]               d_valid,
  input  logic [NUM_LANES-1:0]               d_ready,
  output logic [NUM_LANES-1:0]               d_is_store,
  output logic [LOGSIZE_WIDTH*NUM_LANES-1:0] d_size,
  output logic [DATA_WIDTH*NUM_LANES-1:0]    d_data,
  output logic                               inflight,
  output logic                               error
);

  localparam int unsigned WIDX_W = $clog2(MEM_WORDS);
  localparam int unsigned HI_W   = DATA_WIDTH - BOFF - WIDX_W;

  word_t             mem_q [MEM_WORDS];
  stamp_t            cycle_q;
  logic              error_q;
  logic              inflight_q;

  offset_t           offset   [NUM_LANES];
  logic [WIDX_W-1:0] widx     [NUM_LANES];
  size_t             esize    [NUM_LANES];
  word_t             wdata    [NUM_LANES];
  word_t             merged   [NUM_LANES];
  resp_entry_t       enq_entry[NUM_LANES];
  resp_entry_t       head     [NUM_LANES];
  logic [NUM_LANES-1:0] accept;
  logic [NUM_LANES-1:0] mis;
  logic [NUM_LANES-1:0] wen;
  logic [NUM_LANES-1:0] busy_next;
  logic [NUM_LANES-1:0] unused_lane_bits;

  // Request decode and queue entry build. Loads capture the pre-edge word,
  // which also gives same-cycle load-vs-store its old-data result.
  always_comb begin
    for (int ln = 0; ln < int'(NUM_LANES); ln++) begin
      offset[ln] = a_address[ln*DATA_WIDTH +: BOFF];
      widx[ln]   = a_address[ln*DATA_WIDTH + BOFF +: WIDX_W];
      esize[ln]  = eff_size(a_size[ln*LOGSIZE_WIDTH +: LOGSIZE_WIDTH]);
      wdata[ln]  = a_data[ln*DATA_WIDTH +: DATA_WIDTH];
      mis[ln]    = misaligned(offset[ln], esize[ln]);
      accept[ln] = a_valid[ln] && a_ready[ln];
      wen[ln]    = accept[ln] && a_is_store[ln] && !mis[ln];

      enq_entry[ln].is_store = a_is_store[ln];
      enq_entry[ln].size     = a_size[ln*LOGSIZE_WIDTH +: LOGSIZE_WIDTH];
      enq_entry[ln].data     = a_is_store[ln] ? '0 : mem_q[widx[ln]];
      enq_entry[ln].stamp    = cycle_q;
    end
  end

  // Same-word store conflicts: every writer to a word computes the same fully
  // merged value by folding all writers in ascending lane order, so the
  // highest lane wins overlapping bytes and the parallel writes agree.
  always_comb begin
    for (int ln = 0; ln < int'(NUM_LANES); ln++) begin
      merged[ln] = mem_q[widx[ln]];
      for (int h = 0; h < int'(NUM_LANES); h++) begin
        if (wen[h] && widx[h] == widx[ln]) begin
          merged[ln] = merge_bytes(merged[ln], wdata[h], offset[h], esize[h]);
        end
      end
    end
  end

  // The backing memory is cleared on reset so loads after reset read zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < int'(MEM_WORDS); w++) mem_q[w] <= '0;
      cycle_q    <= '0;
      error_q    <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_q + stamp_t'(1);
      error_q    <= error_q | (|(accept & mis));
      inflight_q <= |busy_next;
      for (int ln = 0; ln < int'(NUM_LANES); ln++) begin
        if (wen[ln]) mem_q[widx[ln]] <= merged[ln];
      end
    end
  end

  assign inflight = inflight_q;
  assign error    = error_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sim_mem_lane_queue #(
      .QUEUE_DEPTH(QUEUE_DEPTH),
      .LATENCY    (LATENCY)
    ) u_queue (
      .clk_i      (clock),
      .rst_n_i    (reset_n),
      .a_valid_i  (a_valid[g]),
      .a_ready_o  (a_ready[g]),
      .enq_entry_i(enq_entry[g]),
      .now_i      (cycle_q),
      .d_valid_o  (d_valid[g]),
      .d_ready_i  (d_ready[g]),
      .head_o     (head[g]),
      .busy_next_o(busy_next[g])
    );

    assign d_is_store[g]                               = head[g].is_store;
    assign d_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH]    = head[g].size;
    assign d_data[g*DATA_WIDTH +: DATA_WIDTH]          = head[g].data;

    // Upper address bits wrap away and the head stamp is internal only.
    assign unused_lane_bits[g] = ^{a_address[g*DATA_WIDTH + BOFF + WIDX_W +: HI_W],
                                   head[g].stamp};
  end

endmodule

// File: tb/tb_sim_mem_responder.sv
module tb_sim_mem_responder;

  localparam int NL  = 4;
  localparam int DW  = 64;
  localparam int LSW = 3;

  logic              clock;
  logic              reset_n;
  logic [NL-1:0]     a_valid, a_ready, a_is_store;
  logic [DW*NL-1:0]  a_address, a_data, d_data;
  logic [LSW*NL-1:0] a_size, d_size;
  logic [NL-1:0]     d_valid, d_ready, d_is_store;
  logic              inflight, error;

  int total;
  int bad;

  sim_mem_responder #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LSW),
    .MEM_WORDS(256), .LATENCY(2), .QUEUE_DEPTH(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_address(a_address),
    .a_is_store(a_is_store), .a_size(a_size), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_is_store(d_is_store),
    .d_size(d_size), .d_data(d_data), .inflight(inflight), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int l, input logic st, input logic [DW-1:0] addr,
                       input logic [LSW-1:0] sz, input logic [DW-1:0] dat);
    a_valid[l]               = 1'b1;
    a_is_store[l]            = st;
    a_address[l*DW +: DW]    = addr;
    a_size[l*LSW +: LSW]     = sz;
    a_data[l*DW +: DW]       = dat;
  endtask

  function automatic logic [DW-1:0] dd(input int l);
    return d_data[l*DW +: DW];
  endfunction

  function automatic logic [LSW-1:0] ds(input int l);
    return d_size[l*LSW +: LSW];
  endfunction

  // Reset values are checked while reset is held, before any release.
  task automatic test_reset();
    reset_n = 1'b0; a_valid = '0; a_is_store = '0; a_address = '0;
    a_size = '0; a_data = '0; d_ready = '1;
    #12;
    total++; if (a_ready !== 4'h0) begin bad++; $display("FAIL rst_a_ready got=%h exp=%h", a_ready, 4'h0); end
    total++; if (d_valid !== 4'h0) begin bad++; $display("FAIL rst_d_valid got=%h exp=%h", d_valid, 4'h0); end
    total++; if (inflight !== 1'b0) begin bad++; $display("FAIL rst_inflight got=%b exp=0", inflight); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b exp=0", error); end
    total++; if (d_data !== '0) begin bad++; $display("FAIL rst_d_data got=%h exp=0", d_data); end
    total++; if (d_size !== '0 || d_is_store !== '0) begin bad++; $display("FAIL rst_d_fields got=%h/%h exp=0/0", d_size, d_is_store); end
    #1 reset_n = 1'b1;
    #1;
    total++; if (a_ready !== 4'hF) begin bad++; $display("FAIL rel_a_ready got=%h exp=%h", a_ready, 4'hF); end
    tick();
  endtask

  task automatic test_load_latency();
    drive(0, 1'b0, 64'h10, 3'd3, 64'h0);
    total++; if (a_ready[0] !== 1'b1) begin bad++; $display("FAIL lat_a_ready got=%b exp=1", a_ready[0]); end
    total++; if (inflight !== 1'b0) begin bad++; $display("FAIL lat_inflight_T got=%b exp=0", inflight); end
    tick(); a_valid = '0;
    total++; if (inflight !== 1'b1) begin bad++; $display("FAIL lat_inflight_T1 got=%b exp=1", inflight); end
    total++; if (d_valid[0] !== 1'b0) begin bad++; $display("FAIL lat_early_valid got=%b exp=0", d_valid[0]); end
    tick();
    total++; if (d_valid !== 4'b0001) begin bad++; $display("FAIL lat_valid_T2 got=%b exp=0001", d_valid); end
    total++; if (dd(0) !== 64'h0) begin bad++; $display("FAIL lat_data got=%h exp=0", dd(0)); end
    total++; if (d_is_store[0] !== 1'b0 || ds(0) !== 3'd3) begin bad++; $display("FAIL lat_fields got=%b/%0d exp=0/3", d_is_store[0], ds(0)); end
    total++; if (inflight !== 1'b1) begin bad++; $display("FAIL lat_inflight_T2 got=%b exp=1", inflight); end
    tick();
    total++; if (d_valid[0] !== 1'b0) begin bad++; $display("FAIL lat_after_deq got=%b exp=0", d_valid[0]); end
    total++; if (inflight !== 1'b0) begin bad++; $display("FAIL lat_inflight_T3 got=%b exp=0", inflight); end
  endtask

  task automatic test_store_load();
    drive(0, 1'b1, 64'h8, 3'd3, 64'hDEADBEEFCAFEF00D);
    tick();
    drive(0, 1'b0, 64'h8, 3'd3, 64'h0);
    tick(); a_valid = '0;
    total++; if (d_valid[0] !== 1'b1 || d_is_store[0] !== 1'b1) begin bad++; $display("FAIL st_resp got=%b/%b exp=1/1", d_valid[0], d_is_store[0]); end
    total++; if (dd(0) !== 64'h0) begin bad++; $display("FAIL st_resp_data got=%h exp=0", dd(0)); end
    tick();
    total++; if (d_valid[0] !== 1'b1 || d_is_store[0] !== 1'b0) begin bad++; $display("FAIL ld_resp got=%b/%b exp=1/0", d_valid[0], d_is_store[0]); end
    total++; if (dd(0) !== 64'hDEADBEEFCAFEF00D) begin bad++; $display("FAIL ld_data got=%h exp=deadbeefcafef00d", dd(0)); end
    tick();
  endtask

  task automatic test_sub_word();
    drive(0, 1'b1, 64'h9, 3'd0, 64'hAB);
    tick();
    drive(0, 1'b0, 64'h8, 3'd3, 64'h0);
    tick();
    drive(0, 1'b1, 64'h9, 3'd1, 64'h1234);
    total++; if (d_valid[0] !== 1'b1 || d_is_store[0] !== 1'b1) begin bad++; $display("FAIL sub_st_resp got=%b/%b exp=1/1", d_valid[0], d_is_store[0]); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL sub_error_pre got=%b exp=0", error); end
    tick();
    drive(0, 1'b0, 64'h8, 3'd3, 64'h0);
    total++; if (dd(0) !== 64'hDEADBEEFCAFEAB0D) begin bad++; $display("FAIL sub_merge got=%h exp=deadbeefcafeab0d", dd(0)); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL sub_error_set got=%b exp=1", error); end
    tick(); a_valid = '0;
    total++; if (d_valid[0] !== 1'b1 || d_is_store[0] !== 1'b1 || dd(0) !== 64'h0) begin bad++; $display("FAIL mis_resp got=%b/%b/%h exp=1/1/0", d_valid[0], d_is_store[0], dd(0)); end
    tick();
    total++; if (dd(0) !== 64'hDEADBEEFCAFEAB0D) begin bad++; $display("FAIL mis_no_write got=%h exp=deadbeefcafeab0d", dd(0)); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL error_sticky got=%b exp=1", error); end
    tick();
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 5; k++) begin
      drive(2, 1'b1, 64'h40 + 64'(8*k), 3'd3, 64'hFACE000000000000 + 64'(k));
      tick();
    end
    a_valid = '0; tick(); tick();
    d_ready[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1'b0, 64'h40 + 64'(8*k), 3'd3, 64'h0);
      total++; if (a_ready[1] !== 1'b1) begin bad++; $display("FAIL bp_ready_%0d got=%b exp=1", k, a_ready[1]); end
      tick();
    end
    drive(1, 1'b0, 64'h60, 3'd3, 64'h0);
    total++; if (a_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", a_ready[1]); end
    // Hold long enough for the stamp counter to wrap.
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (d_valid[1] !== 1'b1 || dd(1) !== 64'hFACE000000000000) begin bad++; $display("FAIL bp_hold_%0d got=%b/%h exp=1/face000000000000", c, d_valid[1], dd(1)); end
    end
    d_ready[1] = 1'b1;
    total++; if (a_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_no_bypass got=%b exp=0", a_ready[1]); end
    tick();
    total++; if (a_ready[1] !== 1'b1) begin bad++; $display("FAIL bp_freed got=%b exp=1", a_ready[1]); end
    total++; if (d_valid[1] !== 1'b1 || dd(1) !== 64'hFACE000000000001) begin bad++; $display("FAIL bp_order_1 got=%b/%h exp=1/face000000000001", d_valid[1], dd(1)); end
    tick(); a_valid = '0;
    for (int k = 2; k < 5; k++) begin
      total++; if (d_valid[1] !== 1'b1 || dd(1) !== 64'hFACE000000000000 + 64'(k)) begin bad++; $display("FAIL bp_order_%0d got=%b/%h exp=1/%h", k, d_valid[1], dd(1), 64'hFACE000000000000 + 64'(k)); end
      tick();
    end
    total++; if (d_valid[1] !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", d_valid[1]); end
  endtask

  task automatic test_conflict();
    drive(0, 1'b1, 64'h20, 3'd3, 64'h1111111111111111);
    drive(3, 1'b1, 64'h20, 3'd3, 64'h3333333333333333);
    drive(1, 1'b0, 64'h20, 3'd3, 64'h0);
    tick(); a_valid = '0;
    drive(2, 1'b0, 64'h20, 3'd3, 64'h0);
    tick(); a_valid = '0;
    total++; if (d_valid !== 4'b1011) begin bad++; $display("FAIL cf_valid got=%b exp=1011", d_valid); end
    total++; if (dd(1) !== 64'h0) begin bad++; $display("FAIL cf_old_data got=%h exp=0", dd(1)); end
    tick();
    total++; if (d_valid[2] !== 1'b1 || dd(2) !== 64'h3333333333333333) begin bad++; $display("FAIL cf_high_lane got=%b/%h exp=1/3333333333333333", d_valid[2], dd(2)); end
    tick();
    // Partial overlap: lane2 byte 1 overrides lane0's word-low bytes.
    drive(0, 1'b1, 64'h28, 3'd2, 64'hAAAAAAAA);
    drive(2, 1'b1, 64'h29, 3'd0, 64'hBB);
    drive(1, 1'b1, 64'h2C, 3'd1, 64'hCCDD);
    tick(); a_valid = '0;
    drive(0, 1'b0, 64'h28, 3'd3, 64'h0);
    tick(); a_valid = '0;
    tick();
    total++; if (dd(0) !== 64'h0000CCDDAAAABBAA) begin bad++; $display("FAIL cf_byte_merge got=%h exp=0000ccddaaaabbaa", dd(0)); end
    tick();
  endtask

  task automatic test_async_reset();
    d_ready = '0;
    drive(0, 1'b0, 64'h8, 3'd3, 64'h0);
    drive(1, 1'b0, 64'h20, 3'd3, 64'h0);
    drive(2, 1'b0, 64'h40, 3'd3, 64'h0);
    tick(); a_valid = '0;
    tick();
    total++; if (d_valid !== 4'b0111 || inflight !== 1'b1) begin bad++; $display("FAIL ar_pre got=%b/%b exp=0111/1", d_valid, inflight); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL ar_pre_error got=%b exp=1", error); end
    #3 reset_n = 1'b0;
    #1;
    total++; if (a_ready !== 4'h0 || d_valid !== 4'h0) begin bad++; $display("FAIL ar_async got=%h/%h exp=0/0", a_ready, d_valid); end
    total++; if (inflight !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL ar_status got=%b/%b exp=0/0", inflight, error); end
    total++; if (d_data !== '0) begin bad++; $display("FAIL ar_d_data got=%h exp=0", d_data); end
    #1 reset_n = 1'b1;
    d_ready = '1;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (d_valid !== 4'h0 || inflight !== 1'b0) begin bad++; $display("FAIL ar_stale_%0d got=%b/%b exp=0/0", c, d_valid, inflight); end
    end
    drive(0, 1'b0, 64'h20, 3'd3, 64'h0);
    drive(1, 1'b0, 64'h8, 3'd3, 64'h0);
    tick(); a_valid = '0;
    tick();
    total++; if (d_valid !== 4'b0011 || dd(0) !== 64'h0) begin bad++; $display("FAIL ar_mem_cleared got=%b/%h exp=0011/0", d_valid, dd(0)); end
    total++; if (dd(1) !== 64'h0) begin bad++; $display("FAIL ar_mem_cleared_w1 got=%h exp=0", dd(1)); end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_latency();
    test_store_load();
    test_sub_word();
    test_backpressure();
    test_conflict();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
